// File: rtl/zero_count_stream.sv
// Per-frame zero/one bit counter over a valid/ready word stream.
// Optional feature: define ZERO_COUNT_SAT_EN for saturating accumulators with out_ovf.
module zero_count_stream #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [CNT_W-1:0] out_beats,
    output logic             out_ovf
);

    localparam int unsigned PC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             mode_q, mode_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] beats_q, beats_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic             beat;
    logic             first_beat;
    logic             eff_mode;
    logic [PC_W-1:0]  word_cnt;
    logic [CNT_W-1:0] acc_next;
    logic [CNT_W-1:0] beats_next;

    function automatic logic [PC_W-1:0] popcount(input logic [WIDTH-1:0] w);
        logic [PC_W-1:0] n;
        n = '0;
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PC_W'(w[i]);
        end
        return n;
    endfunction

    // Mode is taken live on the first beat and from the latch afterwards.
    always_comb begin
        beat       = in_valid && in_ready_q;
        first_beat = (state_q == S_IDLE);
        eff_mode   = first_beat ? mode : mode_q;
        word_cnt   = popcount(eff_mode ? in_data : ~in_data);
    end

`ifdef ZERO_COUNT_SAT_EN
    localparam int unsigned    SUM_W   = ((CNT_W > PC_W) ? CNT_W : PC_W) + 1;
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    logic             ovf_q, ovf_d;
    logic             ovf_next;
    logic [SUM_W-1:0] acc_wide;
    logic [SUM_W-1:0] beats_wide;
    logic             acc_sat;
    logic             beats_sat;

    // Sums are formed one bit wider than either operand so the clip test is exact.
    always_comb begin
        acc_wide   = (first_beat ? '0 : SUM_W'(acc_q)) + SUM_W'(word_cnt);
        beats_wide = (first_beat ? '0 : SUM_W'(beats_q)) + SUM_W'(1);
        acc_sat    = (acc_wide > CNT_MAX);
        beats_sat  = (beats_wide > CNT_MAX);
        acc_next   = acc_sat ? {CNT_W{1'b1}} : acc_wide[CNT_W-1:0];
        beats_next = beats_sat ? {CNT_W{1'b1}} : beats_wide[CNT_W-1:0];
        ovf_next   = (first_beat ? 1'b0 : ovf_q) | acc_sat | beats_sat;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (beat && (state_q != S_HOLD)) begin
            ovf_d = ovf_next;
        end
    end

    assign out_ovf = ovf_q;
`else
    always_comb begin
        acc_next   = (first_beat ? '0 : acc_q) + CNT_W'(word_cnt);
        beats_next = (first_beat ? '0 : beats_q) + CNT_W'(1);
    end

    assign out_ovf = 1'b0;
`endif

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        acc_d       = acc_q;
        beats_d     = beats_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (beat) begin
                    mode_d  = eff_mode;
                    acc_d   = acc_next;
                    beats_d = beats_next;
                    state_d = in_last ? S_HOLD : S_ACCUM;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d  = (state_d != S_HOLD);
        out_valid_d = (state_d == S_HOLD);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            mode_q      <= 1'b0;
            acc_q       <= '0;
            beats_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            acc_q       <= acc_d;
            beats_q     <= beats_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_count = acc_q;
    assign out_beats = beats_q;

endmodule

// File: tb/tb_zero_count_stream.sv
// Directed plus random frames driven into two widths of zero_count_stream,
// checked against a frame-level arithmetic model.
module tb_zero_count_stream;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned BIG_W   = 16;
    localparam int unsigned SMALL_W = 4;
`ifdef ZERO_COUNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset_n;
    logic mode;
    logic in_valid;
    logic in_last;
    logic out_ready;
    logic [WIDTH-1:0] in_data;

    logic rdy_b, vld_b, ovf_b;
    logic rdy_s, vld_s, ovf_s;
    logic [BIG_W-1:0]   cnt_b, beats_b;
    logic [SMALL_W-1:0] cnt_s, beats_s;

    int vectors     = 0;
    int miscompares = 0;

    int total;
    int nbeats;
    bit frame_mode;
    bit in_frame;

    always #5 clk = ~clk;

    zero_count_stream #(.WIDTH(WIDTH), .CNT_W(BIG_W)) u_big (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_b), .in_data(in_data), .in_last(in_last),
        .out_valid(vld_b), .out_ready(out_ready),
        .out_count(cnt_b), .out_beats(beats_b), .out_ovf(ovf_b)
    );

    zero_count_stream #(.WIDTH(WIDTH), .CNT_W(SMALL_W)) u_small (
        .clk(clk), .reset_n(reset_n), .mode(mode),
        .in_valid(in_valid), .in_ready(rdy_s), .in_data(in_data), .in_last(in_last),
        .out_valid(vld_s), .out_ready(out_ready),
        .out_count(cnt_s), .out_beats(beats_s), .out_ovf(ovf_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Frame value as seen through a cw-bit accumulator.
    function automatic int exp_val(input int v, input int cw);
        int lim;
        lim = 1 << cw;
        if (v < lim) return v;
        return SAT ? (lim - 1) : (v % lim);
    endfunction

    function automatic bit exp_ovf(input int cw);
        int lim;
        lim = 1 << cw;
        return SAT && ((total >= lim) || (nbeats >= lim));
    endfunction

    task automatic model_beat(input logic [WIDTH-1:0] d, input bit m);
        if (!in_frame) begin
            frame_mode = m;
            total      = 0;
            nbeats     = 0;
            in_frame   = 1'b1;
        end
        for (int i = 0; i < WIDTH; i++) begin
            if (d[i] == frame_mode) total++;
        end
        nbeats++;
    endtask

    task automatic send_beat(input logic [WIDTH-1:0] d, input bit last, input bit m, input int gaps);
        for (int g = 0; g < gaps; g++) begin
            in_valid = 1'b0;
            in_last  = 1'($urandom);
            in_data  = WIDTH'($urandom);
            mode     = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        mode     = m;
        chk("in_ready_big", 32'(rdy_b), 32'd1);
        chk("in_ready_small", 32'(rdy_s), 32'd1);
        @(posedge clk);
        model_beat(d, m);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid_b"}, 32'(vld_b), 32'd1);
        chk({tag, "_valid_s"}, 32'(vld_s), 32'd1);
        chk({tag, "_ready_b"}, 32'(rdy_b), 32'd0);
        chk({tag, "_ready_s"}, 32'(rdy_s), 32'd0);
        chk({tag, "_count_b"}, 32'(cnt_b), 32'(exp_val(total, BIG_W)));
        chk({tag, "_count_s"}, 32'(cnt_s), 32'(exp_val(total, SMALL_W)));
        chk({tag, "_beats_b"}, 32'(beats_b), 32'(exp_val(nbeats, BIG_W)));
        chk({tag, "_beats_s"}, 32'(beats_s), 32'(exp_val(nbeats, SMALL_W)));
        chk({tag, "_ovf_b"}, 32'(ovf_b), 32'(exp_ovf(BIG_W)));
        chk({tag, "_ovf_s"}, 32'(ovf_s), 32'(exp_ovf(SMALL_W)));
    endtask

    // Called right after the last beat's edge: result must already be up.
    task automatic check_result(input string tag, input int hold);
        check_outputs({tag, "_lat"});
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            in_valid  = 1'($urandom);
            in_data   = WIDTH'($urandom);
            @(posedge clk);
            #1;
            check_outputs({tag, "_hold"});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_done_valid_b"}, 32'(vld_b), 32'd0);
        chk({tag, "_done_valid_s"}, 32'(vld_s), 32'd0);
        chk({tag, "_done_ready_b"}, 32'(rdy_b), 32'd1);
        chk({tag, "_done_ready_s"}, 32'(rdy_s), 32'd1);
        in_frame = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready_b"}, 32'(rdy_b), 32'd1);
        chk({tag, "_ready_s"}, 32'(rdy_s), 32'd1);
        chk({tag, "_valid_b"}, 32'(vld_b), 32'd0);
        chk({tag, "_valid_s"}, 32'(vld_s), 32'd0);
        chk({tag, "_count_b"}, 32'(cnt_b), 32'd0);
        chk({tag, "_count_s"}, 32'(cnt_s), 32'd0);
        chk({tag, "_beats_b"}, 32'(beats_b), 32'd0);
        chk({tag, "_beats_s"}, 32'(beats_s), 32'd0);
        chk({tag, "_ovf_b"}, 32'(ovf_b), 32'd0);
        chk({tag, "_ovf_s"}, 32'(ovf_s), 32'd0);
    endtask

    initial begin
        int len;
        reset_n   = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_frame  = 1'b0;
        total     = 0;
        nbeats    = 0;
        frame_mode = 1'b0;

        #12;
        check_reset_state("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Single-beat frame of all zeros.
        send_beat(8'h00, 1'b1, 1'b0, 0);
        check_result("single", 0);

        // Mixed frame, both modes, then mode toggled after beat 1.
        send_beat(8'hF0, 1'b0, 1'b0, 0);
        send_beat(8'h0F, 1'b0, 1'b0, 0);
        send_beat(8'hFF, 1'b1, 1'b0, 0);
        check_result("mix_m0", 0);
        send_beat(8'hF0, 1'b0, 1'b1, 0);
        send_beat(8'h0F, 1'b0, 1'b1, 0);
        send_beat(8'hFF, 1'b1, 1'b1, 0);
        check_result("mix_m1", 0);
        send_beat(8'hF0, 1'b0, 1'b1, 0);
        send_beat(8'h0F, 1'b0, 1'b0, 0);
        send_beat(8'hFF, 1'b1, 1'b0, 0);
        check_result("mix_toggle", 0);

        // Back-pressure for five cycles in HOLD.
        send_beat(8'hA5, 1'b0, 1'b0, 0);
        send_beat(8'h3C, 1'b1, 1'b0, 0);
        check_result("stall", 5);

        // Overflow of the narrow accumulator.
        send_beat(8'h00, 1'b0, 1'b0, 0);
        send_beat(8'h00, 1'b0, 1'b0, 0);
        send_beat(8'h00, 1'b1, 1'b0, 0);
        check_result("ovf", 1);

        // Reset mid-frame, then a fresh single-beat frame.
        send_beat(8'h12, 1'b0, 1'b0, 0);
        send_beat(8'h34, 1'b0, 1'b0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_state("midreset");
        in_frame = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(8'hFE, 1'b1, 1'b0, 0);
        check_result("after_reset", 0);

        // Bubbles between beats.
        send_beat(8'h00, 1'b0, 1'b0, 3);
        send_beat(8'h00, 1'b1, 1'b0, 4);
        check_result("bubbles", 0);

        // Random frames; occasional long ones push the narrow beat counter past its range.
        for (int f = 0; f < 40; f++) begin
            len = ((f % 8) == 7) ? int'($urandom_range(16, 22)) : int'($urandom_range(1, 6));
            for (int b = 0; b < len; b++) begin
                send_beat(WIDTH'($urandom), (b == len - 1), 1'($urandom),
                          int'($urandom_range(0, 2)));
            end
            check_result("random", int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
